// File: rtl/cordic_nco_prerotate.sv
// NCO phase accumulator and quadrant pre-rotation ahead of the rotation-mode CORDIC chain.
// Folds each sampled phase into [-pi/2, pi/2) and emits the start vector two cycles after stb_in.
module cordic_nco_prerotate #(
  parameter int WIDTH  = 16,
  parameter int ZWIDTH = 24,
  parameter int PWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PWIDTH-1:0] freq_word,
  input  logic              freq_load,
  input  logic [PWIDTH-1:0] mod_in,
  input  logic              phase_clr,
  input  logic [WIDTH-1:0]  amp,
  input  logic              stb_in,
  output logic [WIDTH-1:0]  xo,
  output logic [WIDTH-1:0]  yo,
  output logic [ZWIDTH-1:0] zo,
  output logic              stb_out
);

  // Handshake: stb_in is a one-cycle sample request with no ready; stb_out marks xo/yo/zo
  // valid for exactly that cycle, two cycles after the matching stb_in, with no backpressure.

  localparam logic [ZWIDTH-1:0] QUARTER = {2'b01, {(ZWIDTH-2){1'b0}}};
  localparam logic [WIDTH-1:0]  AMP_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]  AMP_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  logic [PWIDTH-1:0] acc;
  logic [PWIDTH-1:0] freq_reg;
  logic [ZWIDTH-1:0] p_reg;
  logic [WIDTH-1:0]  a_reg;
  logic              v1;

  // Stage 1: sample phase/amplitude and advance the accumulator; clear wins over advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      freq_reg <= '0;
      p_reg    <= '0;
      a_reg    <= '0;
      v1       <= 1'b0;
    end else begin
      v1 <= stb_in;
      if (freq_load) freq_reg <= freq_word;
      if (stb_in) begin
        a_reg <= amp;
        if (phase_clr) begin
          p_reg <= '0;
          acc   <= freq_reg + mod_in;
        end else begin
          p_reg <= acc[PWIDTH-1 -: ZWIDTH];
          acc   <= acc + freq_reg + mod_in;
        end
      end else if (phase_clr) begin
        acc <= '0;
      end
    end
  end

  logic [WIDTH-1:0]  neg_a;
  logic [WIDTH-1:0]  x_next;
  logic [WIDTH-1:0]  y_next;
  logic [ZWIDTH-1:0] z_next;

  // Stage 2 select: quadrants 01/10 rotate by -/+90 degrees so the residual fits the chain.
  always_comb begin
    neg_a  = (a_reg == AMP_MIN) ? AMP_MAX : -a_reg;
    x_next = a_reg;
    y_next = '0;
    z_next = p_reg;
    case (p_reg[ZWIDTH-1 -: 2])
      2'b01: begin
        x_next = '0;
        y_next = a_reg;
        z_next = p_reg - QUARTER;
      end
      2'b10: begin
        x_next = '0;
        y_next = neg_a;
        z_next = p_reg + QUARTER;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xo      <= '0;
      yo      <= '0;
      zo      <= '0;
      stb_out <= 1'b0;
    end else begin
      stb_out <= v1;
      if (v1) begin
        xo <= x_next;
        yo <= y_next;
        zo <= z_next;
      end
    end
  end

endmodule

// File: tb/tb_cordic_nco_prerotate.sv
// Bench for cordic_nco_prerotate: directed scenarios plus random traffic against an
// angle-folding reference model; a negedge monitor checks timing, data and hold behaviour.
module tb_cordic_nco_prerotate;
  localparam int WIDTH  = 16;
  localparam int ZWIDTH = 24;
  localparam int PWIDTH = 32;
  localparam int OW     = 2 * WIDTH + ZWIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic [PWIDTH-1:0] freq_word;
  logic              freq_load;
  logic [PWIDTH-1:0] mod_in;
  logic              phase_clr;
  logic [WIDTH-1:0]  amp;
  logic              stb_in;
  logic [WIDTH-1:0]  xo;
  logic [WIDTH-1:0]  yo;
  logic [ZWIDTH-1:0] zo;
  logic              stb_out;

  cordic_nco_prerotate #(.WIDTH(WIDTH), .ZWIDTH(ZWIDTH), .PWIDTH(PWIDTH)) dut (
    .clk(clk), .rst(rst), .freq_word(freq_word), .freq_load(freq_load),
    .mod_in(mod_in), .phase_clr(phase_clr), .amp(amp), .stb_in(stb_in),
    .xo(xo), .yo(yo), .zo(zo), .stb_out(stb_out)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [OW-1:0] exp_q[$];
  int            due_q[$];
  logic [OW-1:0] last_exp;
  int            errors = 0;
  int            checks = 0;
  bit            mon_en = 0;

  // reference model state: full-turn phase and increment
  logic [PWIDTH-1:0] acc_m;
  logic [PWIDTH-1:0] freq_m;

  // Phase as a signed fraction of pi; fold into [-pi/2, pi/2) by rotating +/-90 degrees.
  function automatic logic [OW-1:0] ref_out(input logic [PWIDTH-1:0] ph, input logic [WIDTH-1:0] a);
    int p, q, av, x, y, z;
    p  = int'($signed(ph[PWIDTH-1 -: ZWIDTH]));
    q  = 1 << (ZWIDTH - 2);
    av = int'($signed(a));
    if (p >= q) begin
      x = 0; y = av; z = p - q;
    end else if (p < -q) begin
      x = 0; y = -av; z = p + q;
      if (y > (1 << (WIDTH - 1)) - 1) y = (1 << (WIDTH - 1)) - 1;
    end else begin
      x = av; y = 0; z = p;
    end
    return {WIDTH'(x), WIDTH'(y), ZWIDTH'(z)};
  endfunction

  // driver: one cycle of stimulus, expected result pushed at issue time
  task automatic drive(input bit stb, input bit clr, input bit fl, input logic [PWIDTH-1:0] fw,
                       input logic [PWIDTH-1:0] md, input logic [WIDTH-1:0] a);
    logic [PWIDTH-1:0] base;
    stb_in = stb; phase_clr = clr; freq_load = fl; freq_word = fw; mod_in = md; amp = a;
    base = clr ? '0 : acc_m;
    if (stb) begin
      exp_q.push_back(ref_out(base, a));
      due_q.push_back(cyc + 2);
      acc_m = base + freq_m + md;
    end else if (clr) begin
      acc_m = '0;
    end
    if (fl) freq_m = fw;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stb_in = 0; phase_clr = 0; freq_load = 0; freq_word = '0; mod_in = '0; amp = '0;
    @(posedge clk);
    #1;
    exp_q.delete();
    due_q.delete();
    last_exp = '0;
    acc_m = '0;
    freq_m = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // monitor: every cycle either a due sample must appear or outputs must hold quietly
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        if (!stb_out) begin
          errors++;
          $display("FAIL missing_stb cyc=%0d got stb_out=0 exp=1", cyc);
        end else if ({xo, yo, zo} !== exp_q[0]) begin
          errors++;
          $display("FAIL data cyc=%0d got x=%h y=%h z=%h exp=%h", cyc, xo, yo, zo, exp_q[0]);
        end
        last_exp = exp_q[0];
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end else if (stb_out) begin
        errors++;
        $display("FAIL unexpected_stb cyc=%0d got stb_out=1 exp=0", cyc);
      end else if ({xo, yo, zo} !== last_exp) begin
        errors++;
        $display("FAIL hold cyc=%0d got x=%h y=%h z=%h exp=%h", cyc, xo, yo, zo, last_exp);
      end
    end
  end

  initial begin
    do_reset();
    mon_en = 1;
    idle(2);

    // single strobe at phase 0
    drive(1, 0, 0, '0, '0, 16'h4000);
    idle(3);

    // quarter-turn increment, five back-to-back strobes
    drive(0, 0, 1, 32'h4000_0000, '0, '0);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, '0, '0, 16'h4000);
    idle(3);

    // negative modulation wraps below zero
    do_reset();
    drive(1, 0, 0, '0, 32'hFFFF_FFFF, 16'h1234);
    drive(1, 0, 0, '0, 32'hFFFF_FFFF, 16'h1234);
    idle(3);

    // -pi exactly with most-negative amplitude: saturating negation
    do_reset();
    drive(0, 0, 1, 32'h8000_0000, '0, '0);
    drive(1, 0, 0, '0, '0, 16'h8000);
    drive(1, 0, 0, '0, '0, 16'h8000);
    drive(1, 0, 0, '0, '0, 16'h8000);
    idle(3);

    // load with strobe uses old increment; clear with strobe restarts at phase 0
    do_reset();
    drive(0, 0, 1, 32'h1000_0000, '0, '0);
    drive(1, 0, 1, 32'h5000_0000, '0, 16'h2000);
    drive(1, 0, 0, '0, '0, 16'h2000);
    drive(1, 1, 0, '0, '0, 16'h2000);
    drive(1, 0, 0, '0, '0, 16'h2000);
    drive(0, 1, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, 16'h2000);
    idle(3);

    // strobe pattern 1,0,0,1,1 with held outputs in the gaps
    drive(0, 0, 1, 32'h2345_6789, '0, '0);
    drive(1, 0, 0, '0, 32'h0000_1000, 16'h7ABC);
    drive(0, 0, 0, '0, '0, '0);
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, 32'hFFF0_0000, 16'h8001);
    drive(1, 0, 0, '0, '0, 16'h0101);
    idle(3);

    // reset between strobes drops the in-flight sample
    drive(1, 0, 0, '0, '0, 16'h3333);
    do_reset();
    idle(4);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [PWIDTH-1:0] md;
      md = ($urandom_range(0, 3) == 0) ? PWIDTH'($urandom) : PWIDTH'($signed(16'($urandom)));
      drive(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 19) == 0),
            bit'($urandom_range(0, 15) == 0), PWIDTH'($urandom), md, WIDTH'($urandom));
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    idle(4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d exp=0", exp_q.size());
    end
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
